// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one REQ/GNT peripheral slave port between NUM_MASTERS requesters.
// Optional WAIT timeout with forced error response is enabled by defining ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int IDX_W          = $clog2(NUM_MASTERS),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        i_CLK,
    input  logic                        i_RSTn,
    input  logic [NUM_MASTERS-1:0]      i_M_REQ,
    input  logic [NUM_MASTERS-1:0]      i_M_WE,
    input  logic [NUM_MASTERS-1:0]      i_M_RE,
    input  logic [32*NUM_MASTERS-1:0]   i_M_ADDR,
    input  logic [32*NUM_MASTERS-1:0]   i_M_WDATA,
    output logic [NUM_MASTERS-1:0]      o_M_GNT,
    output logic [31:0]                 o_M_RDATA,
    output logic                        o_M_ERR,
    output logic                        o_S_REQ,
    output logic                        o_S_CE,
    output logic                        o_S_WE,
    output logic                        o_S_RE,
    output logic [31:0]                 o_S_ADDR,
    output logic [31:0]                 o_S_WDATA,
    input  logic                        i_S_GNT,
    input  logic [31:0]                 i_S_RDATA
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, win_idx_q;
    logic [IDX_W-1:0]       arb_idx, idx_hi, idx_any;
    logic                   hit_hi, hit_any;
    logic                   arb_we, arb_re;
    logic [31:0]            arb_addr, arb_wdata;
    logic                   op_re_q;
    logic                   s_req_q, s_we_q, s_re_q;
    logic [31:0]            s_addr_q, s_wdata_q;
    logic [NUM_MASTERS-1:0] m_gnt_q;
    logic [31:0]            m_rdata_q;
    logic                   tmo_expire;

    // Winner: lowest requester at or above the pointer, else lowest requester overall (wrap).
    always_comb begin
        hit_hi  = 1'b0;
        hit_any = 1'b0;
        idx_hi  = '0;
        idx_any = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (i_M_REQ[j]) begin
                hit_any = 1'b1;
                idx_any = IDX_W'(j);
                if (IDX_W'(j) >= rr_ptr_q) begin
                    hit_hi = 1'b1;
                    idx_hi = IDX_W'(j);
                end
            end
        end
        arb_idx = hit_hi ? idx_hi : idx_any;
    end

    always_comb begin
        arb_we    = 1'b0;
        arb_re    = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (IDX_W'(j) == arb_idx) begin
                arb_we    = i_M_WE[j];
                arb_re    = i_M_RE[j];
                arb_addr  = i_M_ADDR[32*j +: 32];
                arb_wdata = i_M_WDATA[32*j +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hit_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (i_S_GNT || tmo_expire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            op_re_q   <= 1'b0;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_re_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_gnt_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (hit_any) begin
                        win_idx_q <= arb_idx;
                        op_re_q   <= arb_re;
                        s_req_q   <= 1'b1;
                        s_we_q    <= arb_we;
                        s_re_q    <= arb_re;
                        s_addr_q  <= arb_addr;
                        s_wdata_q <= arb_wdata;
                    end
                end
                S_ISSUE: begin
                    s_req_q <= 1'b0;
                    s_we_q  <= 1'b0;
                    s_re_q  <= 1'b0;
                end
                S_WAIT: begin
                    // Slave grant has priority over a coinciding timeout expiry.
                    if (i_S_GNT) begin
                        m_gnt_q   <= NUM_MASTERS'(1) << win_idx_q;
                        m_rdata_q <= op_re_q ? i_S_RDATA : 32'h0;
                    end else if (tmo_expire) begin
                        m_gnt_q   <= NUM_MASTERS'(1) << win_idx_q;
                        m_rdata_q <= 32'hDEAD_BEEF;
                    end
                end
                S_DONE: begin
                    m_gnt_q   <= '0;
                    m_rdata_q <= '0;
                    if (win_idx_q == IDX_W'(NUM_MASTERS - 1))
                        rr_ptr_q <= '0;
                    else
                        rr_ptr_q <= win_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             m_err_q;

    // Expiry fires on the last permitted WAIT cycle, i.e. as the count would reach TIMEOUT_CYCLES.
    assign tmo_expire = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            tmo_cnt_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                tmo_cnt_q <= '0;
            else if (state_q == S_WAIT && !i_S_GNT)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            m_err_q <= tmo_expire && !i_S_GNT;
        end
    end

    assign o_M_ERR = m_err_q;
`else
    assign tmo_expire = 1'b0;
    assign o_M_ERR    = 1'b0;
`endif

    assign o_M_GNT   = m_gnt_q;
    assign o_M_RDATA = m_rdata_q;
    assign o_S_REQ   = s_req_q;
    assign o_S_CE    = s_req_q;
    assign o_S_WE    = s_we_q;
    assign o_S_RE    = s_re_q;
    assign o_S_ADDR  = s_addr_q;
    assign o_S_WDATA = s_wdata_q;

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Shares one memory-mapped peripheral slave port (the timer and similar REQ/GNT peripherals) between NUM_MASTERS requesters (core load/store unit, debug, DMA).
Selects one master round-robin and replays its request to the slave as a single-cycle REQ/CE pulse, then waits for the slave's registered GNT.
Returns read data plus a one-cycle grant to the winning master.
Sits between the core-side interconnect and the peripheral decode.

Parameters:
NUM_MASTERS, 2, number of requesters (legal 2..8).
IDX_W, $clog2(NUM_MASTERS), width of the internal master index and round-robin pointer.
TIMEOUT_CYCLES, 16, maximum WAIT cycles before a forced error response (used only with ARB_TIMEOUT_EN).

Ports:
i_CLK  in  1  clock.
i_RSTn  in  1  asynchronous active-low reset.
i_M_REQ  in  NUM_MASTERS  per-master request; hold until o_M_GNT seen.
i_M_WE  in  NUM_MASTERS  per-master write enable.
i_M_RE  in  NUM_MASTERS  per-master read enable.
i_M_ADDR  in  32*NUM_MASTERS  flattened addresses; master k at [32k+31:32k].
i_M_WDATA  in  32*NUM_MASTERS  flattened write data.
o_M_GNT  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
o_M_RDATA  out  32  read data, valid while o_M_GNT != 0, else 0.
o_M_ERR  out  1  asserted with o_M_GNT on timed-out transaction.
o_S_REQ  out  1  slave request.
o_S_CE  out  1  slave chip enable; always equals o_S_REQ.
o_S_WE  out  1  slave write enable.
o_S_RE  out  1  slave read enable.
o_S_ADDR  out  32  slave address.
o_S_WDATA  out  32  slave write data.
i_S_GNT  in  1  slave grant (registered in slave, one cycle after REQ&CE).
i_S_RDATA  in  32  slave read data, valid with i_S_GNT.

Behaviour:
- All outputs are registered. Reset (async, i_RSTn=0): state IDLE, all outputs 0, rr pointer=0, timeout counter=0.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any i_M_REQ: winner = first set bit scanning from pointer upward, with modulo wrap.
  - Latch the winner index and its WE/RE/ADDR/WDATA; go ISSUE.
  - Else stay IDLE.
- ISSUE (exactly 1 cycle):
  - o_S_REQ=o_S_CE=1; o_S_WE/RE/ADDR/WDATA = latched values.
  - Next state is WAIT.
- WAIT:
  - o_S_REQ=o_S_CE=o_S_WE=o_S_RE=0; ADDR/WDATA hold.
  - On i_S_GNT=1: capture i_S_RDATA; go DONE.
  - i_S_GNT in any other state is ignored.
- DONE (exactly 1 cycle):
  - o_M_GNT[winner]=1; o_M_RDATA = captured data; o_M_ERR per timeout.
  - Pointer <= winner+1, wrapping NUM_MASTERS-1 -> 0. Next state is IDLE.
- Minimum turnaround: request seen at edge 0, slave REQ in cycle 1, slave GNT in cycle 2, master GNT in cycle 3, next arbitration at edge 4.
- Master rule: a master drops i_M_REQ at the edge where it samples o_M_GNT=1, unless it issues a new transaction. Changes to a master's fields during ISSUE/WAIT have no effect on the in-flight transaction.
- Requests arriving while not IDLE wait; there is no queueing beyond the REQ level.
- Simultaneous requests: strict round-robin. The just-served master has lowest priority next round.
- Master with WE=RE=0: still issued, and completes with RDATA=0.
- WE=RE=1: passed through unchanged; the slave defines the outcome.
- Reset mid-transaction aborts silently: no o_M_GNT is generated, and the slave may still respond; that response is ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without i_S_GNT.
  - When the count reaches TIMEOUT_CYCLES, go DONE with o_M_RDATA=32'hDEAD_BEEF and o_M_ERR=1.
  - A late i_S_GNT is ignored.
  - If i_S_GNT and expiry coincide, i_S_GNT wins (no error).
- Undefined: no counter; WAIT persists until i_S_GNT; o_M_ERR is tied 0.

Test Plan:
- Single read: M0 REQ RE=1 ADDR=0x08; slave replies GNT with RDATA=0x1234 -> o_S_REQ/CE high for exactly 1 cycle with ADDR=0x08; o_M_GNT=2'b01 for 1 cycle with RDATA=0x1234, 3 cycles after REQ.
- Write passthrough: M1 WE=1 ADDR=0x10 WDATA=1 -> o_S_WE=1 ADDR=0x10 WDATA=1 for one cycle; o_M_GNT=2'b10, RDATA=0, ERR=0.
- Contention: M0 and M1 request continuously from reset -> slave-side order M0,M1,M0,M1; no master served twice in a row; each grant one-hot.
- Wrap with NUM_MASTERS=3: pointer at 2, requests from M0 and M2 -> M2 served, then M0.
- Async reset asserted during WAIT -> outputs 0 immediately; no o_M_GNT; a late slave GNT after release is ignored; the next request is served normally.
- With ARB_TIMEOUT_EN and a silent slave: single read -> o_M_GNT after 16 WAIT cycles with RDATA=0xDEADBEEF and ERR=1; GNT on cycle 16 exactly -> real data, ERR=0.
